cmd_write: RTL

- Host-side transmitter for SD commands on the CMD line. Serialises the 48-bit command frame: start bit 0, transmission bit 1, 6-bit index, 32-bit argument, CRC7, end bit 1.
- Computes CRC7 on the fly from the outgoing bits.
- Asserts start_listening_o with the timing that the response receiver expects: for one enabled cycle, 2 enabled cycles after the end bit.
- Sits between the command register logic and the CMD pad, alongside the response receiver.

---
 rtl/sdhci_cmd_pkg.sv | 36 +++
 rtl/crc7_write.sv | 50 +++++
 rtl/cmd_write.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/sdhci_cmd_pkg.sv
// -----------------------------------------------------------------------------
// sdhci_cmd_pkg
// Shared definitions for the SD host CMD-line transmitter:
//   - tx_state_e     : transmitter state encoding
//   - frame geometry : CmdFrameLen, CmdCrcStartCnt, CmdEndBitCnt
//   - CmdCrcPoly     : CRC7 polynomial x^7 + x^3 + 1 (x^7 term implicit)
//   - NccCycles      : minimum command spacing used by CMD_WRITE_NCC_EN
//   - crc7_next      : one serial CRC7 step with feedback
// -----------------------------------------------------------------------------
package sdhci_cmd_pkg;

    typedef enum logic [2:0] {
        TX_IDLE      = 3'd0,
        TX_SHIFT_OUT = 3'd1,
        TX_CRC_OUT   = 3'd2,
        TX_END_BIT   = 3'd3,
        TX_GAP       = 3'd4,
        TX_LISTEN    = 3'd5,
        TX_NCC       = 3'd6
    } tx_state_e;

    localparam logic [5:0] CmdFrameLen    = 6'd48;
    localparam logic [5:0] CmdCrcStartCnt = 6'd40;
    localparam logic [5:0] CmdEndBitCnt   = 6'd47;
    localparam logic [6:0] CmdCrcPoly     = 7'h09;
    localparam logic [3:0] NccCycles      = 4'd8;

    // One serial CRC7 step: shift left, fold the polynomial in when the
    // outgoing MSB differs from the incoming data bit.
    function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic data);
        logic fb;
        fb = crc[6] ^ data;
        return {crc[5:0], 1'b0} ^ (fb ? CmdCrcPoly : 7'h00);
    endfunction

endpackage

// File: rtl/crc7_write.sv
// -----------------------------------------------------------------------------
// crc7_write
// Serial CRC7 generator for the outgoing command frame.
// Ports:
//   clk_i, rst_ni   clock and asynchronous active-low reset
//   clk_en_i        SD clock enable; register only moves when high
//   clear_i         zero the CRC (highest priority)
//   shift_in_i      absorb data_i with polynomial feedback
//   shift_out_i     shift towards the MSB without feedback (serialise CRC)
//   data_i          serial data bit being transmitted
//   crc_msb_o       current CRC MSB (next CRC bit on the line)
//   crc_o           full 7-bit CRC register
// -----------------------------------------------------------------------------
module crc7_write
    import sdhci_cmd_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clk_en_i,
    input  logic       clear_i,
    input  logic       shift_in_i,
    input  logic       shift_out_i,
    input  logic       data_i,
    output logic       crc_msb_o,
    output logic [6:0] crc_o
);

    logic [6:0] crc_r;

    // CRC register: clear, accumulate with feedback, or serialise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crc_r <= 7'h00;
        end else if (clk_en_i) begin
            if (clear_i) begin
                crc_r <= 7'h00;
            end else if (shift_in_i) begin
                crc_r <= crc7_next(crc_r, data_i);
            end else if (shift_out_i) begin
                crc_r <= {crc_r[5:0], 1'b0};
            end else begin
                crc_r <= crc_r;
            end
        end
    end

    assign crc_msb_o = crc_r[6];
    assign crc_o     = crc_r;

endmodule

// File: rtl/cmd_write.sv
// -----------------------------------------------------------------------------
// cmd_write
// Host-side SD command transmitter. Serialises the 48-bit frame
// {0, 1, index[5:0], argument[31:0], crc7[6:0], 1} MSB first on the CMD line,
// then strobes start_listening_o/done_o two enabled cycles after the end bit.
// Optional feature macro: CMD_WRITE_NCC_EN -- when defined, an 8 enabled-cycle
// NCC state follows LISTEN before the next command can be accepted.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   clk_en_i             SD clock enable; all state advances only when high
//   start_tx_i           send request, sampled in IDLE on enabled cycles
//   cmd_index_i[5:0]     command index, latched on accept
//   cmd_argument_i[31:0] command argument, latched on accept
//   cmd_o                serial CMD data
//   cmd_en_o             CMD pad output enable
//   busy_o               high from accept until back in IDLE
//   start_listening_o    strobe to the response receiver
//   done_o               one enabled-cycle pulse at frame completion
// -----------------------------------------------------------------------------
module cmd_write
    import sdhci_cmd_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clk_en_i,
    input  logic        start_tx_i,
    input  logic [5:0]  cmd_index_i,
    input  logic [31:0] cmd_argument_i,
    output logic        cmd_o,
    output logic        cmd_en_o,
    output logic        busy_o,
    output logic        start_listening_o,
    output logic        done_o
);

    tx_state_e   state_r;
    logic [39:0] shift_r;
    logic [5:0]  bit_cnt_r;
`ifdef CMD_WRITE_NCC_EN
    logic [3:0]  ncc_cnt_r;
`endif

    logic       crc_clear_s;
    logic       crc_shift_in_s;
    logic       crc_shift_out_s;
    logic       crc_msb_s;
    // Full CRC value is only needed for debug visibility, the line uses the MSB.
    logic [6:0] crc_value_unused_s;

    logic cmd_s;
    logic cmd_en_s;
    logic busy_s;
    logic listen_s;
    logic done_s;

    // CRC sequencing derived from the current state.
    always_comb begin
        crc_clear_s     = 1'b0;
        crc_shift_in_s  = 1'b0;
        crc_shift_out_s = 1'b0;
        case (state_r)
            TX_IDLE:      crc_clear_s     = start_tx_i;
            TX_SHIFT_OUT: crc_shift_in_s  = 1'b1;
            TX_CRC_OUT:   crc_shift_out_s = 1'b1;
            default: begin
                crc_clear_s     = 1'b0;
                crc_shift_in_s  = 1'b0;
                crc_shift_out_s = 1'b0;
            end
        endcase
    end

    crc7_write u_crc7 (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clk_en_i    (clk_en_i),
        .clear_i     (crc_clear_s),
        .shift_in_i  (crc_shift_in_s),
        .shift_out_i (crc_shift_out_s),
        .data_i      (shift_r[39]),
        .crc_msb_o   (crc_msb_s),
        .crc_o       (crc_value_unused_s)
    );

    // Transmit FSM, payload shift register and bit counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= TX_IDLE;
            shift_r   <= 40'h0;
            bit_cnt_r <= 6'd0;
`ifdef CMD_WRITE_NCC_EN
            ncc_cnt_r <= 4'd0;
`endif
        end else if (clk_en_i) begin
            case (state_r)
                TX_IDLE: begin
                    bit_cnt_r <= 6'd0;
                    if (start_tx_i) begin
                        shift_r <= {1'b0, 1'b1, cmd_index_i, cmd_argument_i};
                        state_r <= TX_SHIFT_OUT;
                    end
                end
                TX_SHIFT_OUT: begin
                    shift_r   <= {shift_r[38:0], 1'b0};
                    bit_cnt_r <= bit_cnt_r + 6'd1;
                    // Last payload bit is on the line this cycle.
                    if (bit_cnt_r == (CmdCrcStartCnt - 6'd1)) begin
                        state_r <= TX_CRC_OUT;
                    end
                end
                TX_CRC_OUT: begin
                    bit_cnt_r <= bit_cnt_r + 6'd1;
                    if (bit_cnt_r == (CmdEndBitCnt - 6'd1)) begin
                        state_r <= TX_END_BIT;
                    end
                end
                TX_END_BIT: begin
                    state_r <= TX_GAP;
                end
                TX_GAP: begin
                    state_r <= TX_LISTEN;
                end
                TX_LISTEN: begin
`ifdef CMD_WRITE_NCC_EN
                    ncc_cnt_r <= 4'd0;
                    state_r   <= TX_NCC;
`else
                    state_r   <= TX_IDLE;
`endif
                end
`ifdef CMD_WRITE_NCC_EN
                TX_NCC: begin
                    ncc_cnt_r <= ncc_cnt_r + 4'd1;
                    if (ncc_cnt_r == (NccCycles - 4'd1)) begin
                        state_r <= TX_IDLE;
                    end
                end
`endif
                default: begin
                    state_r <= TX_IDLE;
                end
            endcase
        end
    end

    // Output decode from registered state; holds naturally across disabled cycles.
    always_comb begin
        cmd_s    = 1'b1;
        cmd_en_s = 1'b0;
        busy_s   = 1'b1;
        listen_s = 1'b0;
        done_s   = 1'b0;
        case (state_r)
            TX_IDLE: begin
                busy_s = 1'b0;
            end
            TX_SHIFT_OUT: begin
                cmd_s    = shift_r[39];
                cmd_en_s = 1'b1;
            end
            TX_CRC_OUT: begin
                cmd_s    = crc_msb_s;
                cmd_en_s = 1'b1;
            end
            TX_END_BIT: begin
                cmd_en_s = 1'b1;
            end
            TX_GAP: begin
                cmd_en_s = 1'b0;
            end
            TX_LISTEN: begin
                listen_s = 1'b1;
                done_s   = 1'b1;
            end
            TX_NCC: begin
                cmd_en_s = 1'b0;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    assign cmd_o             = cmd_s;
    assign cmd_en_o          = cmd_en_s;
    assign busy_o            = busy_s;
    assign start_listening_o = listen_s;
    assign done_o            = done_s;

endmodule
